cacheline_adaptor: RTL and testbench

Bridges the 256-bit cacheline interface of the eviction write buffer to the 64-bit burst interface of physical memory. Each line read or write from the buffer becomes one 4-beat memory burst. The block assembles read beats into a full line, serializes write lines into beats, and returns a single-cycle completion pulse upstream. It sits directly downstream of the eviction write buffer control and datapath, and directly upstream of the memory port.

---
 rtl/cacheline_adaptor.sv | 99 +++++++++
 tb/tb_cacheline_adaptor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit cacheline requests from the eviction write buffer to 4-beat
// 64-bit memory bursts; assembles read beats and serializes write lines.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int BEATS   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [31:0]        address_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    input  logic               resp_i
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFS_W = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  rd_line;
    logic [LINE_W-1:0]  wr_line;
    logic [31:0]        addr_reg;
    logic               last_beat;
    logic               unused_ofs;

    // Byte offset within the line is dropped; the burst always starts aligned.
    assign unused_ofs = ^address_i[OFS_W-1:0];
    assign last_beat  = resp_i && (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (write_i)     state_n = WR_BURST;
                else if (read_i) state_n = RD_BURST;
            end
            RD_BURST: if (last_beat) state_n = RD_DONE;
            RD_DONE:  state_n = IDLE;
            WR_BURST: if (last_beat) state_n = WR_DONE;
            WR_DONE:  state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Read and write lines live in separate registers so line_o survives
    // intervening write bursts until the next read overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_line  <= '0;
            wr_line  <= '0;
            addr_reg <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (write_i) begin
                        wr_line  <= line_i;
                        addr_reg <= {address_i[31:OFS_W], OFS_W'(0)};
                        cnt      <= '0;
                    end else if (read_i) begin
                        addr_reg <= {address_i[31:OFS_W], OFS_W'(0)};
                        cnt      <= '0;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        rd_line[cnt*BURST_W +: BURST_W] <= burst_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign line_o    = rd_line;
    assign address_o = addr_reg;
    assign read_o    = (state == RD_BURST);
    assign write_o   = (state == WR_BURST);
    assign resp_o    = (state == RD_DONE) || (state == WR_DONE);
    assign burst_o   = wr_line[cnt*BURST_W +: BURST_W];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed vector table, reset
// corner cases, and randomized transactions against a line-level model.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
    logic [31:0]  address_i, address_o;
    logic [255:0] line_i, line_o;
    logic [63:0]  burst_i, burst_o;

    int checks = 0;
    int errors = 0;
    logic [255:0] last_rd = '0;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
        .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .burst_i(burst_i), .burst_o(burst_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        bit           both;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [31:0]  stall;
        logic [31:0]  exp_addr;
        int           gap;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_zero(input string name);
        chk({name, "_line"}, line_o, '0);
        chk({name, "_ctl"}, {resp_o, read_o, write_o}, 3'b000);
        chk({name, "_addr"}, address_o, '0);
        chk({name, "_burst"}, burst_o, '0);
    endtask

    // Idle cycles: memory noise on resp_i must be ignored, read line must hold.
    task automatic idle(input int n);
        read_i = 0; write_i = 0;
        repeat (n) begin
            resp_i = 1'($urandom); burst_i = {$urandom, $urandom}; address_i = $urandom;
            @(negedge clk);
            chk("idle_ctl", {resp_o, read_o, write_o}, 3'b000);
            chk("idle_line", line_o, last_rd);
        end
        resp_i = 0;
    endtask

    // One line transaction, called at a negedge; returns at the negedge of the DONE cycle.
    task automatic txn(input bit wr, input bit both, input logic [31:0] addr,
                       input logic [255:0] data, input logic [31:0] stall,
                       input logic [31:0] exp_addr, input bit rnd);
        int  cyc, k;
        bit  ack;
        write_i = wr; read_i = !wr || both; address_i = addr;
        line_i = wr ? data : rnd_line(); resp_i = 0;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (!(read_o || write_o)) chk("pre_resp", resp_o, 1'b0);
        end while (!(read_o || write_o) && cyc < 4);
        chk("busy", {read_o, write_o}, wr ? 2'b01 : 2'b10);
        if (!(read_o || write_o)) begin
            read_i = 0; write_i = 0;
            return;
        end
        k = 0; cyc = 0;
        while (k < 4 && cyc < 64) begin
            chk("burst_ctl", {resp_o, read_o, write_o}, wr ? 3'b001 : 3'b010);
            chk("burst_addr", address_o, exp_addr);
            if (wr) chk($sformatf("burst_o_beat%0d", k), burst_o, data[k*64 +: 64]);
            address_i = $urandom;
            if (wr) line_i = rnd ? rnd_line() : '0;
            if (rnd) begin read_i = 1'($urandom); write_i = 1'($urandom); end
            ack = rnd ? ($urandom_range(0, 2) != 0) : !(cyc < 32 && stall[cyc]);
            resp_i  = ack;
            burst_i = (ack && !wr) ? data[k*64 +: 64] : {$urandom, $urandom};
            @(negedge clk);
            cyc++;
            if (ack) k++;
        end
        chk("burst_timeout", k, 4);
        read_i = 0; write_i = 0;
        resp_i = 1'($urandom); burst_i = {$urandom, $urandom};
        chk("done_ctl", {resp_o, read_o, write_o}, 3'b100);
        if (!wr) last_rd = data;
        chk(wr ? "done_line_held" : "done_line", line_o, last_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 32'h0000_1234,
                    {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
                    32'h0, 32'h0000_1220, 5};
        vecs[1] = '{1, 0, 32'h0000_8010,
                    {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}},
                    32'h16, 32'h0000_8000, 2};
        vecs[2] = '{1, 1, 32'hFFFF_FFFF,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h5A5A_5A5A_A5A5_A5A5, 64'hDEAD_BEEF_CAFE_F00D},
                    32'h5, 32'hFFFF_FFE0, 1};
        vecs[3] = '{1, 0, 32'h0000_0040,
                    {64'h4444_0000_4444_0000, 64'h3333_0000_3333_0000,
                     64'h2222_0000_2222_0000, 64'h1111_0000_1111_0000},
                    32'h0, 32'h0000_0040, 0};
        vecs[4] = '{0, 0, 32'hABCD_EF1F,
                    {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                     64'hFFFF_EEEE_DDDD_CCCC, 64'hBBBB_AAAA_9999_8888},
                    32'h2, 32'hABCD_EF00, 3};

        rst = 1; read_i = 0; write_i = 0; resp_i = 0;
        address_i = '0; line_i = '0; burst_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_zero("reset_idle");
        end

        for (int i = 0; i < 5; i++) begin
            txn(vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].data,
                vecs[i].stall, vecs[i].exp_addr, 0);
            idle(vecs[i].gap);
        end

        // Reset in the middle of a read: partial line discarded, no completion.
        read_i = 1; address_i = 32'h0000_2000;
        @(negedge clk);
        chk("rst_mid_busy", read_o, 1'b1);
        for (int b = 0; b < 2; b++) begin
            resp_i = 1; burst_i = {2{32'h9999_0000 + 32'(b)}};
            @(negedge clk);
        end
        resp_i = 0; rst = 1;
        @(negedge clk);
        rst = 0; read_i = 0;
        chk_zero("rst_mid");
        last_rd = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_noresp", {resp_o, read_o, write_o}, 3'b000);
            chk("rst_mid_line", line_o, '0);
        end
        txn(0, 0, 32'h0000_2008, {64'h4, 64'h3, 64'h2, 64'h1}, 32'h0, 32'h0000_2000, 0);
        idle(1);

        for (int t = 0; t < 30; t++) begin
            logic [31:0]  a;
            logic [255:0] d;
            bit           w;
            a = $urandom; d = rnd_line(); w = 1'($urandom);
            txn(w, w && $urandom_range(0, 1) == 1, a, d, 32'h0, a & ~32'h1F, 1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
